// File: rtl/otl_core_regif.sv
// otl_core_regif: per-core register responder terminating the OTL write/read channels
module otl_core_regif #(
  parameter int ADDRW = 32,
  parameter int DATAW = 32,
  parameter logic [3:0] CORE_ID = 4'h1,
  parameter int NREG = 8,
  parameter logic [DATAW-1:0] ID_VALUE = 32'h0711_0001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATAW-1:0]      wrdata,
  input  logic [ADDRW-1:0]      wraddr,
  input  logic                  wrvalid,
  output logic                  wrready,
  input  logic [ADDRW-1:0]      rdaddr,
  input  logic                  rdready,
  output logic [DATAW-1:0]      rddata,
  output logic                  rdvalid,
  input  logic [DATAW-1:0]      status_in,
  output logic [NREG*DATAW-1:0] ctrl_q,
  output logic [NREG-1:0]       wr_pulse,
  output logic [7:0]            err_count
);
  localparam int IW = $clog2(NREG);
  localparam logic [9:0] NR = 10'(NREG);
  typedef enum logic {W_IDLE, W_BUSY} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t w_state;
  r_state_t r_state;
  logic [9:0] widx, ridx;
  logic w_ok, r_ok, w_go, r_go, w_err, r_err;
  logic [DATAW-1:0] r_val;
  logic [8:0] err_sum;
  logic unused_addr;
  assign unused_addr = ^{wraddr, rdaddr};
  assign widx = wraddr[11:2];
  assign ridx = rdaddr[11:2];
  assign w_ok = wraddr[15:12] == CORE_ID && widx < NR && widx > 10'd1;
  assign r_ok = rdaddr[15:12] == CORE_ID && ridx < NR;
  assign w_go = w_state == W_IDLE && wrready && wrvalid;
  assign r_go = r_state == R_IDLE && rdready;
  assign w_err = w_go && !w_ok;
  assign r_err = r_go && !r_ok;
  assign err_sum = {1'b0, err_count} + 9'(w_err) + 9'(r_err);
  // Slots 0/1 of ctrl_q are never written, so reads of idx 0/1 must bypass them
  assign r_val = !r_ok ? '0 :
                 ridx == 10'd0 ? ID_VALUE :
                 ridx == 10'd1 ? status_in :
                 ctrl_q[int'(ridx[IW-1:0])*DATAW +: DATAW];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state  <= W_IDLE;
      wrready  <= 1'b0;
      ctrl_q   <= '0;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      case (w_state)
        W_IDLE: begin
          wrready <= !w_go;
          if (w_go) begin
            w_state <= W_BUSY;
            if (w_ok) begin
              ctrl_q[int'(widx[IW-1:0])*DATAW +: DATAW] <= wrdata;
              wr_pulse[widx[IW-1:0]] <= 1'b1;
            end
          end
        end
        default: begin
          w_state <= W_IDLE;
          wrready <= 1'b1;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      rdvalid <= 1'b0;
      rddata  <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (rdready) begin
          r_state <= R_DATA;
          rdvalid <= 1'b1;
          rddata  <= r_val;
        end
        default: if (rdready) begin
          r_state <= R_IDLE;
          rdvalid <= 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_count <= '0;
    else err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
  end
endmodule

// File: tb/tb_otl_core_regif.sv
// tb_otl_core_regif: randomized self-checking bench with an address-map reference model
module tb_otl_core_regif;
  logic clk = 0, rst_n = 0;
  logic [31:0] wrdata = 0, wraddr = 0, rdaddr = 0, status_in = 0;
  logic wrvalid = 0, rdready = 0;
  logic wrready, rdvalid;
  logic [31:0] rddata;
  logic [255:0] ctrl_q;
  logic [7:0] wr_pulse, err_count;
  int checks = 0, fails = 0;
  logic [31:0] mregs [8];
  int merr = 0;

  otl_core_regif dut (
    .clk(clk), .rst_n(rst_n), .wrdata(wrdata), .wraddr(wraddr), .wrvalid(wrvalid),
    .wrready(wrready), .rdaddr(rdaddr), .rdready(rdready), .rddata(rddata),
    .rdvalid(rdvalid), .status_in(status_in), .ctrl_q(ctrl_q), .wr_pulse(wr_pulse),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = 0;
    merr = 0;
  endfunction

  function automatic void bump_err(int n);
    merr = (merr + n > 255) ? 255 : merr + n;
  endfunction

  function automatic logic [255:0] exp_ctrl();
    logic [255:0] v = 0;
    for (int i = 2; i < 8; i++) v[i*32 +: 32] = mregs[i];
    return v;
  endfunction

  // Returns the expected wr_pulse vector and updates the model
  function automatic logic [7:0] model_write(logic [31:0] a, logic [31:0] d);
    int idx = int'(a[11:2]);
    logic [7:0] p = 0;
    if (a[15:12] == 4'h1 && idx >= 2 && idx < 8) begin
      mregs[idx] = d;
      p[idx] = 1'b1;
    end else bump_err(1);
    return p;
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] a, logic [31:0] st);
    int idx = int'(a[11:2]);
    if (a[15:12] != 4'h1 || idx >= 8) begin
      bump_err(1);
      return 0;
    end
    if (idx == 0) return 32'h0711_0001;
    if (idx == 1) return st;
    return mregs[idx];
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    while (!wrready && n < 10) begin tick(); n++; end
    if (!wrready) begin
      checks++; fails++;
      $display("FAIL wrready_timeout got=%0b want=1", wrready);
    end
    wrvalid = 1; wraddr = a; wrdata = d;
    tick();
    wrvalid = 0;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 0;
    #3;
    checks++; if (wrready !== 0 || rdvalid !== 0 || rddata !== 0) begin fails++; $display("FAIL reset_hs wrready=%0b rdvalid=%0b rddata=%h want 0/0/0", wrready, rdvalid, rddata); end
    checks++; if (ctrl_q !== 0 || wr_pulse !== 0 || err_count !== 0) begin fails++; $display("FAIL reset_regs ctrl_q=%h wr_pulse=%h err=%0d want 0", ctrl_q, wr_pulse, err_count); end
    tick(); tick();
    rst_n = 1;
    #1;
    checks++; if (wrready !== 0) begin fails++; $display("FAIL wrready_before_edge got=%0b want=0", wrready); end
    tick();
    checks++; if (wrready !== 1) begin fails++; $display("FAIL wrready_after_edge got=%0b want=1", wrready); end
  endtask

  task automatic test_id();
    rdready = 1; rdaddr = 32'h1000;
    tick();
    checks++; if (rdvalid !== 1 || rddata !== 32'h0711_0001) begin fails++; $display("FAIL id_read rdvalid=%0b rddata=%h want 1/07110001", rdvalid, rddata); end
    tick();
    rdready = 0;
    checks++; if (rdvalid !== 0) begin fails++; $display("FAIL id_complete rdvalid=%0b want 0", rdvalid); end
  endtask

  task automatic test_write_readback();
    logic [7:0] p;
    logic [31:0] e;
    p = model_write(32'h1008, 32'hA5A5_0003);
    do_write(32'h1008, 32'hA5A5_0003);
    checks++; if (ctrl_q[64 +: 32] !== 32'hA5A5_0003) begin fails++; $display("FAIL wr_slot2 got=%h want=a5a50003", ctrl_q[64 +: 32]); end
    checks++; if (wr_pulse !== p || p !== 8'b0000_0100) begin fails++; $display("FAIL wr_pulse got=%b want=%b", wr_pulse, p); end
    checks++; if (wrready !== 0) begin fails++; $display("FAIL wr_busy got=%0b want=0", wrready); end
    tick();
    checks++; if (wr_pulse !== 0 || wrready !== 1) begin fails++; $display("FAIL wr_after pulse=%b wrready=%0b want 0/1", wr_pulse, wrready); end
    e = model_read(32'h1008, status_in);
    rdready = 1; rdaddr = 32'h1008;
    tick();
    checks++; if (rddata !== e || rdvalid !== 1) begin fails++; $display("FAIL readback got=%h want=%h", rddata, e); end
    tick();
    rdready = 0;
  endtask

  task automatic test_illegal();
    logic [31:0] wa [3] = '{32'h2008, 32'h1004, 32'h1020};
    logic [7:0] p;
    logic [31:0] e;
    for (int i = 0; i < 3; i++) begin
      p = model_write(wa[i], 32'hDEAD_BEEF);
      do_write(wa[i], 32'hDEAD_BEEF);
      checks++; if (err_count !== 8'(merr) || wr_pulse !== p || ctrl_q !== exp_ctrl()) begin fails++; $display("FAIL illegal_wr_%0d err=%0d want=%0d pulse=%b ctrl_ok=%0b", i, err_count, merr, wr_pulse, ctrl_q === exp_ctrl()); end
      tick();
    end
    e = model_read(32'h1040, status_in);
    rdready = 1; rdaddr = 32'h1040;
    tick();
    checks++; if (rddata !== e || rdvalid !== 1 || err_count !== 8'(merr)) begin fails++; $display("FAIL illegal_rd rddata=%h want=%h err=%0d want=%0d", rddata, e, err_count, merr); end
    tick();
    rdready = 0;
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    status_in = 32'hCAFE_0001;
    e = model_read(32'h1004, status_in);
    rdready = 1; rdaddr = 32'h1004;
    tick();
    rdready = 0;
    checks++; if (rdvalid !== 1 || rddata !== e) begin fails++; $display("FAIL bp_start rdvalid=%0b rddata=%h want 1/%h", rdvalid, rddata, e); end
    for (int i = 0; i < 5; i++) begin
      status_in = $urandom;
      tick();
      checks++; if (rdvalid !== 1 || rddata !== e) begin fails++; $display("FAIL bp_hold_%0d rdvalid=%0b rddata=%h want 1/%h", i, rdvalid, rddata, e); end
    end
    rdready = 1;
    tick();
    rdready = 0;
    checks++; if (rdvalid !== 0) begin fails++; $display("FAIL bp_drop rdvalid=%0b want 0", rdvalid); end
  endtask

  task automatic test_collision();
    logic [7:0] p;
    logic [31:0] e;
    p = model_write(32'h100C, 32'h11);
    do_write(32'h100C, 32'h11);
    tick();
    e = model_read(32'h100C, status_in);
    p = model_write(32'h100C, 32'h55);
    wrvalid = 1; wraddr = 32'h100C; wrdata = 32'h55;
    rdready = 1; rdaddr = 32'h100C;
    tick();
    wrvalid = 0;
    checks++; if (rdvalid !== 1 || rddata !== e || e !== 32'h11) begin fails++; $display("FAIL coll_read got=%h want=%h", rddata, e); end
    checks++; if (ctrl_q[96 +: 32] !== 32'h55 || wr_pulse !== p) begin fails++; $display("FAIL coll_write slot3=%h want=00000055 pulse=%b want=%b", ctrl_q[96 +: 32], wr_pulse, p); end
    tick();
    rdready = 0;
  endtask

  task automatic test_random();
    logic [31:0] a, e;
    logic [7:0] p;
    for (int it = 0; it < 60; it++) begin
      a = $urandom;
      a[15:12] = ($urandom_range(0, 3) == 0) ? 4'h2 : 4'h1;
      a[11:2] = 10'($urandom_range(0, 9));
      status_in = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        e = $urandom;
        p = model_write(a, e);
        do_write(a, e);
        checks++; if (wr_pulse !== p || wrready !== 0) begin fails++; $display("FAIL rnd_wr_%0d addr=%h pulse=%b want=%b wrready=%0b", it, a, wr_pulse, p, wrready); end
        checks++; if (ctrl_q !== exp_ctrl() || err_count !== 8'(merr)) begin fails++; $display("FAIL rnd_wr_state_%0d addr=%h err=%0d want=%0d ctrl_ok=%0b", it, a, err_count, merr, ctrl_q === exp_ctrl()); end
        tick();
      end else begin
        e = model_read(a, status_in);
        rdready = 1; rdaddr = a;
        tick();
        checks++; if (rdvalid !== 1 || rddata !== e || err_count !== 8'(merr)) begin fails++; $display("FAIL rnd_rd_%0d addr=%h got=%h want=%h err=%0d want=%0d", it, a, rddata, e, err_count, merr); end
        tick();
        rdready = 0;
        checks++; if (rdvalid !== 0) begin fails++; $display("FAIL rnd_rd_done_%0d rdvalid=%0b want 0", it, rdvalid); end
      end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] p;
    logic [31:0] e;
    while (merr < 254) begin
      p = model_write(32'h2000, 0);
      do_write(32'h2000, 0);
      tick();
    end
    checks++; if (err_count !== 8'd254) begin fails++; $display("FAIL sat_254 got=%0d want=254", err_count); end
    for (int i = 0; i < 40; i++) begin
      p = model_write(32'h2000, 0);
      e = model_read(32'h3000, status_in);
      wrvalid = 1; wraddr = 32'h2000; rdready = 1; rdaddr = 32'h3000;
      tick();
      wrvalid = 0;
      if (i == 0) begin
        checks++; if (err_count !== 8'd255 || merr != 255) begin fails++; $display("FAIL sat_pair got=%0d want=255", err_count); end
      end
      tick();
      rdready = 0;
    end
    checks++; if (err_count !== 8'(merr) || err_count !== 8'd255) begin fails++; $display("FAIL sat_hold got=%0d want=255", err_count); end
  endtask

  task automatic test_reset_mid_read();
    rdready = 1; rdaddr = 32'h1008;
    tick();
    rdready = 0;
    checks++; if (rdvalid !== 1 || ctrl_q === 0) begin fails++; $display("FAIL mid_pre rdvalid=%0b ctrl_q=%h want 1/nonzero", rdvalid, ctrl_q); end
    #2 rst_n = 0;
    #1;
    model_reset();
    checks++; if (rdvalid !== 0 || rddata !== 0 || ctrl_q !== exp_ctrl() || err_count !== 8'(merr) || wrready !== 0) begin fails++; $display("FAIL mid_reset rdvalid=%0b rddata=%h ctrl_q=%h err=%0d wrready=%0b want all 0", rdvalid, rddata, ctrl_q, err_count, wrready); end
    tick();
    rst_n = 1;
    tick();
    checks++; if (wrready !== 1 || rdvalid !== 0) begin fails++; $display("FAIL post_reset wrready=%0b rdvalid=%0b want 1/0", wrready, rdvalid); end
  endtask

  initial begin
    test_reset();
    test_id();
    test_write_readback();
    test_illegal();
    test_backpressure();
    test_collision();
    test_random();
    test_saturation();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
